// File: rtl/regfile_pkg.sv
// Shared types, register constants and destination decoding for the register file write path.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  typedef enum logic [1:0] {
    DST_RC = 2'b00,
    DST_RB = 2'b01,
    DST_RA = 2'b10,
    DST_XP = 2'b11
  } regdst_e;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = REG_ADDR_W'(0);
  localparam logic [REG_ADDR_W-1:0] REG_XP   = REG_ADDR_W'(1);
  localparam logic [REG_ADDR_W-1:0] REG_RA   = REG_ADDR_W'(31);

  function automatic logic [REG_ADDR_W-1:0] resolve_dst(
    input logic [1:0]            code,
    input logic [REG_ADDR_W-1:0] rb,
    input logic [REG_ADDR_W-1:0] rc
  );
    case (regdst_e'(code))
      DST_RA:  return REG_RA;
      DST_XP:  return REG_XP;
      DST_RB:  return rb;
      default: return rc;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter: lowest request at or above ptr wins, else lowest overall.
// Combinational, no state; the caller owns and advances ptr.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] hi;
  logic [N-1:0] pick;

  always_comb begin
    hi    = req & ~((N'(1) << ptr) - N'(1));
    pick  = (|hi) ? hi : req;
    grant = pick & (~pick + N'(1));
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates N_REQ writeback requesters onto the register file write port; one cycle accept->RegWrite.
// stall freezes grants and the output stage. Define REGFILE_WR_BYPASS_EN for fwd_a/fwd_b/fwd_data.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [2*N_REQ-1:0]       req_dst,
  input  logic [ADDR_W*N_REQ-1:0]  req_rb,
  input  logic [ADDR_W*N_REQ-1:0]  req_rc,
  input  logic [DATA_W*N_REQ-1:0]  req_wdata,
  input  logic                     stall,
  input  logic [ADDR_W-1:0]        ra,
  input  logic [ADDR_W-1:0]        rb,
  output logic                     RegWrite,
  output logic [1:0]               RegDst,
  output logic [ADDR_W-1:0]        rc,
  output logic [DATA_W-1:0]        wdata,
  output logic                     ra_hazard,
  output logic                     rb_hazard,
`ifdef REGFILE_WR_BYPASS_EN
  output logic                     fwd_a,
  output logic                     fwd_b,
  output logic [DATA_W-1:0]        fwd_data,
`endif
  output logic [7:0]               drop_cnt
);

  localparam int NRR = N_REQ - 1;
  localparam int RPW = (NRR > 1) ? $clog2(NRR) : 1;

  // rr_idx counts from requester 1: rr_idx == k means requester k+1 is looked at first.
  logic [RPW-1:0]    rr_idx;
  logic [RPW-1:0]    rr_win;
  logic [RPW-1:0]    rr_next;
  logic [NRR-1:0]    rr_grant;
  logic [N_REQ-1:0]  grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              out_valid;
  logic              hz_a;
  logic              hz_b;

  rr_arbiter #(.N(NRR), .PW(RPW)) u_rr (
    .req   (req_valid[N_REQ-1:1]),
    .ptr   (rr_idx),
    .grant (rr_grant)
  );

  always_comb begin
    grant = '0;
    if (!stall) grant = req_valid[0] ? N_REQ'(1) : {rr_grant, 1'b0};
  end

  assign req_ready = grant;

  always_comb begin
    win_addr = '0;
    win_data = '0;
    rr_win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_addr = resolve_dst(req_dst[2*i +: 2], req_rb[ADDR_W*i +: ADDR_W],
                               req_rc[ADDR_W*i +: ADDR_W]);
        win_data = req_wdata[DATA_W*i +: DATA_W];
      end
    end
    for (int j = 0; j < NRR; j++) begin
      if (rr_grant[j]) rr_win = RPW'(j);
    end
  end

  assign rr_next = (rr_win == RPW'(NRR - 1)) ? '0 : rr_win + RPW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      rc        <= '0;
      wdata     <= '0;
      rr_idx    <= '0;
      drop_cnt  <= '0;
    end else if (!stall) begin
      out_valid <= |grant;
      if (|grant) begin
        rc    <= win_addr;
        wdata <= win_data;
        if (win_addr == REG_ZERO && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
      if (|grant[N_REQ-1:1]) rr_idx <= rr_next;
    end
  end

  assign RegDst   = 2'b00;
  assign RegWrite = out_valid & ~stall & (rc != REG_ZERO);
  assign hz_a     = out_valid & (rc == ra) & (ra != REG_ZERO);
  assign hz_b     = out_valid & (rc == rb) & (rb != REG_ZERO);

`ifdef REGFILE_WR_BYPASS_EN
  assign fwd_a     = hz_a;
  assign fwd_b     = hz_b;
  assign fwd_data  = wdata;
  assign ra_hazard = 1'b0;
  assign rb_hazard = 1'b0;
`else
  assign ra_hazard = hz_a;
  assign rb_hazard = hz_b;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: vector table plus scoreboard of expected writes.
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready;
  logic [2*N-1:0]  req_dst;
  logic [AW*N-1:0] req_rb, req_rc;
  logic [DW*N-1:0] req_wdata;
  logic            stall;
  logic [AW-1:0]   ra, rb;
  logic            RegWrite;
  logic [1:0]      RegDst;
  logic [AW-1:0]   rc;
  logic [DW-1:0]   wdata;
  logic            ra_hazard, rb_hazard;
  logic [7:0]      drop_cnt;
`ifdef REGFILE_WR_BYPASS_EN
  logic            fwd_a, fwd_b;
  logic [DW-1:0]   fwd_data;
`endif

  regfile_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_rb(req_rb), .req_rc(req_rc), .req_wdata(req_wdata),
    .stall(stall), .ra(ra), .rb(rb), .RegWrite(RegWrite), .RegDst(RegDst),
    .rc(rc), .wdata(wdata), .ra_hazard(ra_hazard), .rb_hazard(rb_hazard),
`ifdef REGFILE_WR_BYPASS_EN
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_data(fwd_data),
`endif
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [N-1:0]          valid;
    logic [N-1:0][1:0]     dst;
    logic [N-1:0][AW-1:0]  rbf;
    logic [N-1:0][AW-1:0]  rcf;
    logic [N-1:0][DW-1:0]  data;
    logic                  stall;
    logic [AW-1:0]         ra;
    logic [AW-1:0]         rb;
    logic [N-1:0]          exp_ready;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  sb[$];
  wr_t  cur;
  logic cur_vld = 1'b0;
  int   exp_drop = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] valid, input logic [N-1:0] exp, input logic st);
    vec_t v;
    v.valid = valid;   v.dst = '0;   v.rbf = '0;  v.rcf = '0;  v.data = '0;
    v.stall = st;      v.ra = '0;    v.rb = '0;   v.exp_ready = exp;
    return v;
  endfunction

  function automatic wr_t expect_wr(input vec_t v, input int i);
    wr_t w;
    case (v.dst[i])
      2'b10:   w.addr = 5'd31;
      2'b11:   w.addr = 5'd1;
      2'b01:   w.addr = v.rbf[i];
      default: w.addr = v.rcf[i];
    endcase
    w.data = v.data[i];
    return w;
  endfunction

  function automatic logic hz(input logic [AW-1:0] a);
    return cur_vld && (cur.addr == a) && (a != 0);
  endfunction

  task automatic drive(input vec_t v);
    req_valid = v.valid;  req_dst = v.dst;   req_rb = v.rbf;  req_rc = v.rcf;
    req_wdata = v.data;   stall   = v.stall; ra     = v.ra;   rb     = v.rb;
  endtask

  // One cycle: drive, check combinational and output-stage values, then advance the model.
  task automatic run(input vec_t v);
    int g;
    drive(v);
    #1;
    chk("req_ready", 32'(req_ready), 32'(v.exp_ready));
    chk("RegWrite", 32'(RegWrite), 32'(cur_vld && cur.addr != 0 && !v.stall));
`ifdef REGFILE_WR_BYPASS_EN
    chk("ra_hazard", 32'(ra_hazard), 32'(0));
    chk("fwd_a", 32'(fwd_a), 32'(hz(v.ra)));
    chk("fwd_b", 32'(fwd_b), 32'(hz(v.rb)));
    if (cur_vld) chk("fwd_data", fwd_data, cur.data);
`else
    chk("ra_hazard", 32'(ra_hazard), 32'(hz(v.ra)));
    chk("rb_hazard", 32'(rb_hazard), 32'(hz(v.rb)));
`endif
    if (cur_vld) begin
      chk("rc", 32'(rc), 32'(cur.addr));
      chk("wdata", wdata, cur.data);
    end
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    g = -1;
    for (int i = 0; i < N; i++) if (v.exp_ready[i]) g = i;
    if (g >= 0 && !v.stall) sb.push_back(expect_wr(v, g));
    @(posedge clk); #1;
    if (!v.stall) begin
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        cur_vld = 1'b1;
        if (cur.addr == 0 && exp_drop < 255) exp_drop++;
      end else begin
        cur_vld = 1'b0;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    drive(mk('0, '0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    chk("rst_RegWrite", 32'(RegWrite), 32'(0));
    chk("rst_rc", 32'(rc), 32'(0));
    chk("rst_wdata", wdata, 32'(0));
    chk("rst_RegDst", 32'(RegDst), 32'(0));
    chk("rst_drop_cnt", 32'(drop_cnt), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(0));
    chk("rst_hazard", 32'({ra_hazard, rb_hazard}), 32'(0));
    reset_n = 1'b1;

    // Requesters 1 and 2 held valid: grants alternate 1,2,1,2 then wrap back to 1.
    for (int k = 0; k < 5; k++) begin
      v = mk(3'b110, (k % 2 == 0) ? 3'b010 : 3'b100, 1'b0);
      v.rcf[1] = 5'd3;  v.data[1] = 32'h11;
      v.rcf[2] = 5'd4;  v.data[2] = 32'h22;
      tbl.push_back(v);
    end
    tbl.push_back(mk('0, '0, 1'b0));
    // Single write from requester 1, then hazard on ra.
    v = mk(3'b010, 3'b010, 1'b0);  v.rcf[1] = 5'd5;  v.data[1] = 32'hDEADBEEF;
    tbl.push_back(v);
    v = mk('0, '0, 1'b0);  v.ra = 5'd5;  v.rb = 5'd6;
    tbl.push_back(v);
    // Exception and requester 1 together: exception first, requester 1 next cycle.
    v = mk(3'b011, 3'b001, 1'b0);
    v.dst[0] = 2'b11;  v.data[0] = 32'h400;  v.rcf[1] = 5'd7;  v.data[1] = 32'h77;
    v.ra = 5'd1;
    tbl.push_back(v);
    v = mk(3'b010, 3'b010, 1'b0);  v.rcf[1] = 5'd7;  v.data[1] = 32'h77;  v.ra = 5'd1;
    tbl.push_back(v);
    v = mk('0, '0, 1'b0);  v.rb = 5'd7;
    tbl.push_back(v);
    // $ra write held three cycles by stall; requester 1 waits with changing data.
    v = mk(3'b100, 3'b100, 1'b0);  v.dst[2] = 2'b10;  v.data[2] = 32'h1004;
    tbl.push_back(v);
    for (int k = 0; k < 3; k++) begin
      v = mk(3'b010, 3'b000, 1'b1);  v.rcf[1] = 5'd8;  v.data[1] = 32'hA0 + 32'(k);
      v.ra = 5'd31;
      tbl.push_back(v);
    end
    v = mk(3'b010, 3'b010, 1'b0);  v.rcf[1] = 5'd8;  v.data[1] = 32'hAB;  v.ra = 5'd31;
    tbl.push_back(v);
    tbl.push_back(mk('0, '0, 1'b0));

    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // Writes to $zero: accepted, never issued, counter saturates.
    for (int k = 0; k < 300; k++) begin
      v = mk(3'b010, 3'b010, 1'b0);
      v.dst[1] = 2'b01;  v.rbf[1] = 5'd0;  v.rcf[1] = 5'd9;  v.data[1] = 32'(k);
      run(v);
    end
    run(mk('0, '0, 1'b0));
    chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);

    // Asynchronous reset with a write in flight.
    v = mk(3'b010, 3'b010, 1'b0);  v.rcf[1] = 5'd9;  v.data[1] = 32'h99;
    run(v);
    v = mk('0, '0, 1'b0);  v.ra = 5'd9;
    drive(v);
    #1;
    chk("pre_rst_RegWrite", 32'(RegWrite), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_RegWrite", 32'(RegWrite), 32'(0));
    chk("async_rst_hazard", 32'(ra_hazard), 32'(0));
    chk("async_rst_drop_cnt", 32'(drop_cnt), 32'(0));
    sb.delete();
    cur_vld  = 1'b0;
    exp_drop = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    v = mk(3'b110, 3'b010, 1'b0);
    v.rcf[1] = 5'd3;  v.data[1] = 32'h31;  v.rcf[2] = 5'd4;  v.data[2] = 32'h42;
    run(v);
    run(mk('0, '0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between N_REQ writeback requesters: exception/$XP, ALU writeback, load writeback and jal link.
- Resolves each requester's destination code to a physical register and registers the winning write for one cycle.
- Drives the register file's RegWrite/RegDst/rc/wdata inputs.
- Reports read-after-write hazards against the in-flight write to the decode stage.

Parameters:
N_REQ, 3, number of requesters (index 0 = exception, highest priority); legal range 2..8
DATA_W, 32, write data width
ADDR_W, 5, register address width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
req_valid  in  N_REQ  write request per requester
req_ready  out  N_REQ  grant/accept per requester (combinational)
req_dst  in  2*N_REQ  destination code per requester: 00 rc, 01 rb, 10 $ra (31), 11 $xp (1)
req_rb  in  ADDR_W*N_REQ  rt field per requester
req_rc  in  ADDR_W*N_REQ  rd field per requester
req_wdata  in  DATA_W*N_REQ  write data per requester
stall  in  1  freezes the write port
ra, rb  in  ADDR_W  decode-stage read addresses, for hazard check
RegWrite  out  1  to register file
RegDst  out  2  to register file; constant 2'b00
rc  out  ADDR_W  resolved write address to register file
wdata  out  DATA_W  write data to register file
ra_hazard, rb_hazard  out  1  read address matches the in-flight write
drop_cnt  out  8  saturating count of accepted writes to $zero

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset values:
  - out_valid=0; RegWrite=0; rc=0; wdata=0; RegDst=00.
  - rr_ptr=1; drop_cnt=0; req_ready=0; hazards=0.
- Address resolution, per requester:
  - 10 -> 31; 11 -> 1; 01 -> req_rb; 00 -> req_rc.
- Arbitration, combinational, only when stall=0:
  - If req_valid[0] is set, requester 0 wins.
  - Otherwise, round-robin over 1..N_REQ-1, starting at rr_ptr.
  - Exactly one req_ready is high: the winner's, only while its valid is high. A transfer occurs on valid&ready at the clock edge.
- rr_ptr update: on a grant to i≥1, rr_ptr <= i+1, wrapping N_REQ-1 -> 1. Unchanged on a grant to 0 or when idle.
- Latency: exactly one cycle from accept to RegWrite.
  - Output register loads the winner's resolved address and data.
  - out_valid <= 1 if a grant occurred, else 0.
  - RegWrite = out_valid & ~stall & (rc != 0).
  - Throughput is 1 write/cycle.
- $zero writes: a resolved address of 0 is still accepted, produces no RegWrite, and increments drop_cnt, which saturates at 255.
- stall=1:
  - All req_ready low; output register, rr_ptr and drop_cnt hold.
  - RegWrite low; the held write is issued on the first cycle after stall falls.
- Hazards:
  - ra_hazard = out_valid & (rc==ra) & (ra!=0); rb_hazard likewise.
  - Both remain valid during stall.
- Simultaneous requests: requester 0 always beats the others. Losers keep valid asserted and stay pending; no request is ever lost.
- Reset asserted mid-operation discards the in-flight write immediately (asynchronous).
- Requester data changes while not ready are ignored.

Optional Feature:
REGFILE_WR_BYPASS_EN
- Defined: adds outputs fwd_a, fwd_b (1) and fwd_data (DATA_W).
  - fwd_a/fwd_b assert on the same conditions as the hazards, and fwd_data = wdata.
  - ra_hazard/rb_hazard are tied 0, so decode consumes the forwarded value and need not stall.
- Undefined: no forward ports; hazards behave as above.

Decomposition:
- Package regfile_pkg:
  - Typedef regdst_e {DST_RC=2'b00, DST_RB=2'b01, DST_RA=2'b10, DST_XP=2'b11}.
  - Constants REG_ZERO=0, REG_XP=1, REG_RA=31.
  - ADDR_W/DATA_W defaults.
  - Function resolve_dst(code, rb, rc).
- Sub-module rr_arbiter (N parameter; req, ptr -> one-hot grant) is natural and instantiated once for requesters 1..N_REQ-1.

Test Plan:
- Req1 dst=00, rc=5, wdata=0xDEADBEEF, single cycle -> req_ready[1]=1; next cycle RegWrite=1, rc=5, wdata=0xDEADBEEF; ra=5 gives ra_hazard=1.
- Req0 (dst=11, data 0x400) and req1 (rc=7) valid together -> req0 first (rc=1, 0x400), req1 next cycle (rc=7); two back-to-back RegWrite pulses.
- Req1 and req2 held valid 4 cycles -> grants alternate 1,2,1,2; rr_ptr wraps 2 -> 1.
- Req2 dst=10, data 0x1004 with stall=1 for 3 cycles in the output stage -> RegWrite low for 3 cycles, then one pulse with rc=31, 0x1004; no other grant while stalled.
- Req1 dst=01 with rb=0, repeated 300 times -> never RegWrite; drop_cnt saturates at 255.
- reset_n low mid-cycle with out_valid=1 -> RegWrite drops immediately; after release, rr_ptr=1 and drop_cnt=0.
